// File: rtl/input_bank_pkg.sv
// Register offsets and decoder select codes for the input bank register window.
// Shared by the decoder and read mux in the top level.
package input_bank_pkg;

    localparam logic [31:0] OFF_SW_STATE  = 32'h0;
    localparam logic [31:0] OFF_BTN_STATE = 32'h4;
    localparam logic [31:0] OFF_BTN_PEND  = 32'h8;
    localparam logic [31:0] OFF_IRQ_EN    = 32'hC;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_SW_STATE,
        SEL_BTN_STATE,
        SEL_BTN_PEND,
        SEL_IRQ_EN
    } reg_sel_e;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus per-bit stable-count debouncer; a steady input change reaches
// stable_o 2+DEBOUNCE_CYCLES edges later, rise_o flags the edge where a bit goes 0->1 (no backpressure).
module input_debouncer #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] rise_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Counter only advances while the synced value disagrees; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_q[i];
                    rise_d[i]   = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            meta_q   <= raw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_d;

endmodule

// File: rtl/input_bank_mmio.sv
// Memory-mapped switch/button bank with W1C press flags and a maskable level interrupt.
// Reads return one cycle after re; bus is always ready, no backpressure.
module input_bank_mmio
    import input_bank_pkg::*;
#(
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTN         = 4,
    parameter logic [31:0] BASE_ADDR       = 32'h00002000,
    parameter int          DEBOUNCE_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address,
    input  logic               we,
    input  logic               re,
    input  logic [31:0]        wdata,
    input  logic [NUM_SW-1:0]  switches,
    input  logic [NUM_BTN-1:0] buttons,
    output logic [31:0]        rdata,
    output logic               irq
);

    logic [NUM_SW-1:0]  sw_stable;
    logic [NUM_SW-1:0]  sw_rise;
    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] btn_rise;

    logic [NUM_BTN-1:0] pend_q,   pend_d;
    logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
    logic [NUM_BTN-1:0] pend_clr;
    logic [31:0]        rdata_q,  rdata_d;
    logic               irq_q,    irq_d;
    reg_sel_e           sel;

    input_debouncer #(
        .WIDTH           (NUM_SW),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sw_deb (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (switches),
        .stable_o (sw_stable),
        .rise_o   (sw_rise)
    );

    input_debouncer #(
        .WIDTH           (NUM_BTN),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_deb (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (buttons),
        .stable_o (btn_stable),
        .rise_o   (btn_rise)
    );

    // Full-width compare also rejects misaligned addresses inside the window.
    always_comb begin
        sel = SEL_NONE;
        if (address == BASE_ADDR + OFF_SW_STATE) begin
            sel = SEL_SW_STATE;
        end else if (address == BASE_ADDR + OFF_BTN_STATE) begin
            sel = SEL_BTN_STATE;
        end else if (address == BASE_ADDR + OFF_BTN_PEND) begin
            sel = SEL_BTN_PEND;
        end else if (address == BASE_ADDR + OFF_IRQ_EN) begin
            sel = SEL_IRQ_EN;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (re) begin
            case (sel)
                SEL_SW_STATE:  rdata_d = 32'(sw_stable);
                SEL_BTN_STATE: rdata_d = 32'(btn_stable);
                SEL_BTN_PEND:  rdata_d = 32'(pend_q);
                SEL_IRQ_EN:    rdata_d = 32'(irq_en_q);
                default:       rdata_d = '0;
            endcase
        end
    end

    // A press landing on the same edge as its clear stays pending.
    always_comb begin
        pend_clr = '0;
        irq_en_d = irq_en_q;
        if (we && sel == SEL_BTN_PEND) begin
            pend_clr = wdata[NUM_BTN-1:0];
        end
        if (we && sel == SEL_IRQ_EN) begin
            irq_en_d = wdata[NUM_BTN-1:0];
        end
        pend_d = (pend_q & ~pend_clr) | btn_rise;
        irq_d  = |(pend_q & irq_en_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q   <= '0;
            irq_en_q <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            irq_en_q <= irq_en_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign rdata = rdata_q;
    assign irq   = irq_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, wdata, sw_rise};

endmodule

// File: tb/tb_input_bank_mmio.sv
// Bench for input_bank_mmio: directed and random bus/pin stimulus, expected rdata/irq
// derived from a window-based reference model and compared by a separate monitor.
module tb_input_bank_mmio;

    localparam int          NSW  = 16;
    localparam int          NBTN = 4;
    localparam int          DC   = 4;
    localparam logic [31:0] BASE = 32'h00002000;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     address;
    logic            we;
    logic            re;
    logic [31:0]     wdata;
    logic [NSW-1:0]  switches;
    logic [NBTN-1:0] buttons;
    logic [31:0]     rdata;
    logic            irq;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    input_bank_mmio #(
        .NUM_SW          (NSW),
        .NUM_BTN         (NBTN),
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .address  (address),
        .we       (we),
        .re       (re),
        .wdata    (wdata),
        .switches (switches),
        .buttons  (buttons),
        .rdata    (rdata),
        .irq      (irq)
    );

    // Reference model: pins pass a 2-deep delay line; a debounced bit flips once the last
    // DC delayed samples all disagree with it. Bits [19:16] are buttons, [15:0] switches.
    logic [19:0] m_s1, m_s2, m_st;
    logic [19:0] m_win [DC];
    logic [3:0]  m_pend, m_en;
    logic [31:0] exp_rd_q [$];
    logic        exp_irq_q [$];

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [19:0] st,
                                           input logic [3:0] pend, input logic [3:0] en);
        case (a)
            BASE:          return {16'h0, st[15:0]};
            BASE + 32'h4:  return {28'h0, st[19:16]};
            BASE + 32'h8:  return {28'h0, pend};
            BASE + 32'hC:  return {28'h0, en};
            default:       return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [19:0] nst;
        logic [3:0]  clr;
        logic [31:0] e_rd;
        logic        e_irq;
        logic        all_diff;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_pend = '0; m_en = '0;
            for (int k = 0; k < DC; k++) m_win[k] = '0;
            exp_rd_q.push_back(32'h0);
            exp_irq_q.push_back(1'b0);
        end else begin
            e_rd  = re ? m_read(address, m_st, m_pend, m_en) : 32'h0;
            e_irq = |(m_pend & m_en);
            for (int k = DC - 1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = m_s2;
            nst = m_st;
            for (int i = 0; i < 20; i++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DC; k++) all_diff &= (m_win[k][i] != m_st[i]);
                if (all_diff) nst[i] = ~m_st[i];
            end
            clr    = (we && address == BASE + 32'h8) ? wdata[3:0] : 4'h0;
            m_pend = (m_pend & ~clr) | (nst[19:16] & ~m_st[19:16]);
            if (we && address == BASE + 32'hC) m_en = wdata[3:0];
            m_st = nst;
            m_s2 = m_s1;
            m_s1 = {buttons, switches};
            exp_rd_q.push_back(e_rd);
            exp_irq_q.push_back(e_irq);
        end
    end

    // Monitor: every posedge yields one expected (rdata, irq) pair, checked at the next negedge.
    initial begin : monitor
        logic [31:0] er;
        logic        ei;
        forever begin
            @(negedge clk);
            if (exp_rd_q.size() > 0) begin
                er = exp_rd_q.pop_front();
                ei = exp_irq_q.pop_front();
                checks++;
                if (rdata !== er)
                    $display("FAIL rdata @%0t: got %h expected %h", $time, rdata, er);
                else
                    passed++;
                checks++;
                if (irq !== ei)
                    $display("FAIL irq @%0t: got %b expected %b", $time, irq, ei);
                else
                    passed++;
            end
        end
    end

    task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        re      = r;
        we      = w;
        address = a;
        wdata   = d;
        @(negedge clk);
    endtask

    logic [31:0] addr_tab [7];

    initial begin
        rst = 1'b0; re = 1'b0; we = 1'b0; address = '0; wdata = '0;
        switches = '0; buttons = '0;
        addr_tab = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC,
                     BASE + 32'h10, BASE + 32'h2, BASE + 32'h9};

        // Reset with switches high, then watch SW_STATE appear after 2+DC edges.
        switches = 16'hFFFF;
        repeat (3) step(1, 0, BASE, 0);
        rst = 1'b1;
        repeat (9) step(1, 0, BASE, 0);

        // Bounce on button 0, then hold.
        foreach (addr_tab[j]) begin
            if (j < 4) begin
                buttons[0] = ~j[0];
                step(1, 0, BASE + 32'h4, 0);
            end
        end
        buttons[0] = 1'b1;
        repeat (8) step(1, 0, BASE + 32'h4, 0);
        repeat (2) step(1, 0, BASE + 32'h8, 0);
        step(0, 1, BASE + 32'h8, 32'h1);
        buttons[0] = 1'b0;
        repeat (8) step(1, 0, BASE + 32'h8, 0);

        // Interrupt enable, press, ineffective and effective clears.
        step(0, 1, BASE + 32'hC, 32'h4);
        buttons[2] = 1'b1;
        repeat (8) step(1, 0, BASE + 32'h8, 0);
        step(0, 1, BASE + 32'h8, 32'h1);
        step(1, 0, BASE + 32'h8, 0);
        step(0, 1, BASE + 32'h8, 32'h4);
        repeat (3) step(1, 0, BASE + 32'h8, 0);
        buttons[2] = 1'b0;
        repeat (7) step(0, 0, 0, 0);

        // Clear of bit 1 issued on every edge up to and including its debounce edge.
        buttons[1] = 1'b1;
        for (int k = 0; k < 2 + DC; k++) step(0, 1, BASE + 32'h8, 32'h2);
        repeat (3) step(1, 0, BASE + 32'h8, 0);
        buttons[1] = 1'b0;
        step(0, 1, BASE + 32'h8, 32'hF);
        repeat (7) step(1, 0, BASE + 32'h4, 0);

        // Decode corners and read-during-write.
        step(1, 0, BASE + 32'h10, 0);
        step(1, 0, BASE + 32'h2, 0);
        step(0, 1, BASE, 32'hFFFF_FFFF);
        step(1, 0, BASE, 0);
        step(0, 1, BASE + 32'hC, 32'hFFFF_FFFF);
        step(1, 0, BASE + 32'hC, 0);
        step(1, 1, BASE + 32'hC, 32'h0);
        step(1, 0, BASE + 32'hC, 0);

        // Reset while button 3 is mid-count, keep holding through and after reset.
        step(0, 1, BASE + 32'hC, 32'h8);
        buttons[3] = 1'b1;
        repeat (4) step(1, 0, BASE + 32'h8, 0);
        rst = 1'b0;
        repeat (2) step(1, 0, BASE + 32'h8, 0);
        rst = 1'b1;
        repeat (10) step(1, 0, BASE + 32'h8, 0);
        buttons[3] = 1'b0;
        step(0, 1, BASE + 32'h8, 32'hF);
        repeat (7) step(1, 0, BASE + 32'h4, 0);

        // Random traffic with slowly changing pins and rare resets.
        for (int n = 0; n < 600; n++) begin
            int sw_idx;
            int bt_idx;
            int op;
            sw_idx = $urandom_range(0, NSW - 1);
            bt_idx = $urandom_range(0, NBTN - 1);
            if ($urandom_range(0, 7) == 0) switches[sw_idx] = ~switches[sw_idx];
            if ($urandom_range(0, 5) == 0) buttons[bt_idx] = ~buttons[bt_idx];
            rst = ($urandom_range(0, 249) != 0);
            op  = $urandom_range(0, 3);
            step(op != 2, op >= 2, addr_tab[$urandom_range(0, 6)], $urandom());
        end

        rst = 1'b1;
        re  = 1'b0;
        we  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/input_bank_mmio.md
Name: input_bank_mmio

Overview:
- Memory-mapped input peripheral for the Nexys top level; successor to the fixed single-register switch reader.
- Synchronises and debounces NUM_SW switches and NUM_BTN buttons.
- Latches button press events into write-1-to-clear pending flags and raises a maskable interrupt.
- Answers CPU bus reads in a small register window at BASE_ADDR.

Parameters:
- NUM_SW, 16, number of switch inputs (1..32).
- NUM_BTN, 4, number of button inputs (1..32).
- BASE_ADDR, 32'h00002000, byte address of register 0; window is 16 bytes.
- DEBOUNCE_CYCLES, 100000, stable-cycle count before a debounced bit changes (>=2; bench uses 4).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- address  input  32  CPU byte address.
- we  input  1  write strobe, sampled at posedge.
- re  input  1  read strobe, sampled at posedge.
- wdata  input  32  write data.
- switches  input  NUM_SW  raw asynchronous switch pins.
- buttons  input  NUM_BTN  raw asynchronous button pins.
- rdata  output  32  registered read data.
- irq  output  1  level interrupt.

Behaviour:
- Register map (offset from BASE_ADDR):
  - +0x0 SW_STATE: RO, debounced switches, zero-extended.
  - +0x4 BTN_STATE: RO, debounced buttons, zero-extended.
  - +0x8 BTN_PEND: R/W1C.
  - +0xC IRQ_EN: RW, low NUM_BTN bits; upper bits read 0.
- Address decode: full 32-bit compare against BASE_ADDR+offset; address[1:0] must be 0.
- Reset (rst==0 at posedge): sync flops, debounced state, counters, BTN_PEND, IRQ_EN, rdata all 0; irq 0 the cycle after reset is sampled.
- Input path per bit:
  - Two-flop synchroniser, then debouncer holding a counter and a stable value.
  - sync == stable: counter cleared.
  - sync != stable: counter increments; when counter == DEBOUNCE_CYCLES-1 and still differing, stable <= sync and counter clears.
  - Any glitch back to stable before then clears the counter; no change results.
  - Latency: pin change held steady -> debounced bit changes 2+DEBOUNCE_CYCLES posedges later.
  - Counter width is $clog2(DEBOUNCE_CYCLES); no wrap possible.
- Press detect:
  - Debounced button 0->1 transition sets BTN_PEND[i] the same cycle stable updates (visible next cycle).
  - Release sets nothing.
- W1C:
  - we at BTN_PEND clears bits where wdata is 1.
  - Same-cycle set and clear on one bit: set wins.
- Writes to SW_STATE/BTN_STATE and unmapped addresses are ignored; IRQ_EN write takes wdata[NUM_BTN-1:0].
- Reads:
  - re at posedge -> rdata valid after that edge (1-cycle latency).
  - Unmapped address or re==0 -> rdata 0 on next cycle.
  - Read never clears state.
  - Simultaneous re and we to the same register returns the pre-write value.
- irq = |(BTN_PEND & IRQ_EN), registered (one cycle after the pending/enable change).
- Reset mid-debounce discards the in-progress count; a still-pressed button after reset re-debounces from stable 0 and generates a fresh pend.

Decomposition:
- Package input_bank_pkg: register offset localparams (OFF_SW_STATE, OFF_BTN_STATE, OFF_BTN_PEND, OFF_IRQ_EN) and the register-select enum used by the decoder.
- Sub-module input_debouncer: parameter WIDTH, DEBOUNCE_CYCLES; synchroniser plus per-bit counters; outputs stable vector and one-cycle rise pulse vector.
- Instantiated twice: switches and buttons.

Test Plan:
- Reset: rst=0 for 3 cycles with switches=16'hFFFF -> rdata 0, irq 0; after release and 2+4 cycles, read 0x2000 -> 32'h0000FFFF.
- Bounce rejection: button[0] toggles 1,0,1,0 every cycle then held 1 -> BTN_STATE bit0 sets exactly 6 cycles after final rising edge; BTN_PEND reads 32'h1 once.
- Interrupt: write IRQ_EN=32'h4, press button[2] -> irq=1; write BTN_PEND=32'h4 -> irq=0 next cycle; write 32'h1 has no effect on bit2.
- Set/clear collision: W1C of bit1 on the same cycle button[1] debounces high -> BTN_PEND bit1 remains 1.
- Decode: read 0x2010 and 0x2002 -> 0; write 0x2000 with 32'hFFFFFFFF -> SW_STATE unchanged; IRQ_EN readback masks to 32'hF.
- Reset mid-operation: assert rst while button[3] pressed with count 2 -> after release of rst, pend bit3 set 6 cycles later, not earlier.
